servo_pwm_decoder: RTL and testbench

- Receive side of the servo PWM link: measures the high time of an incoming 20 ms servo pulse train and decodes it back to the 3-bit position code the servo driver emits.
- Sits on the radar feedback/loopback path; lets the controller verify commanded servo position and detect a dead or out-of-spec PWM line.
- Counts in clk cycles (50 MHz, 1_000_000 cycles = 20 ms frame).

---
 rtl/servo_pwm_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures pulse high time and decodes the 3-bit position.
// Define PWM_GLITCH_FILTER_EN to insert a FILTER_LEN-sample stability filter.
module servo_pwm_decoder #(
    parameter int MIN_PULSE     = 40_000,
    parameter int MAX_PULSE     = 300_000,
    parameter int FRAME_TIMEOUT = 1_100_000,
    parameter int LOCK_COUNT    = 2,
    parameter int FILTER_LEN    = 8,
    parameter int TH_010        = 99_500,
    parameter int TH_011        = 134_500,
    parameter int TH_100        = 166_000,
    parameter int TH_101        = 199_000,
    parameter int TH_110        = 232_000,
    parameter int TH_111        = 261_500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [2:0]  ctr_out,
    output logic [20:0] width_out,
    output logic        valid,
    output logic        locked,
    output logic        err
);

    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [LW-1:0] LC = LW'(LOCK_COUNT);
    localparam logic [20:0] FT   = 21'(FRAME_TIMEOUT);
    localparam logic [20:0] MAXW = 21'(MAX_PULSE);
    localparam logic [20:0] MINW = 21'(MIN_PULSE);

    typedef enum logic [1:0] {
        WAIT_LOW,
        ARMED,
        HIGH,
        LOW
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic           lvl_q, lvl_d;
    logic           primed_q, primed_d;
    logic           eval_q, eval_d;
    logic [20:0]    width_q, width_d;
    logic [20:0]    frame_q, frame_d;
    logic [20:0]    wout_q, wout_d;
    logic [2:0]     ctr_q, ctr_d;
    logic           valid_q, valid_d;
    logic           locked_q, locked_d;
    logic           err_q, err_d;
    logic [LW-1:0]  lock_q, lock_d;
    logic           lvl, quiet, rise, fall, tmo, drop;

`ifdef PWM_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
`endif

    function automatic logic [2:0] decode(input logic [20:0] w);
        logic [2:0] c;
        if      (w < 21'(TH_010)) c = 3'b001;
        else if (w < 21'(TH_011)) c = 3'b010;
        else if (w < 21'(TH_100)) c = 3'b011;
        else if (w < 21'(TH_101)) c = 3'b100;
        else if (w < 21'(TH_110)) c = 3'b101;
        else if (w < 21'(TH_111)) c = 3'b110;
        else                      c = 3'b111;
        return c;
    endfunction

    always_comb begin
        sync1_d  = pwm_in;
        sync2_d  = sync1_q;
        primed_d = 1'b1;
`ifdef PWM_GLITCH_FILTER_EN
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = sync2_q;
            else fcnt_d = fcnt_q + 1'b1;
        end
        lvl   = filt_q;
        quiet = !sync1_q && !sync2_q && !filt_q && !lvl_q;
`else
        lvl   = sync2_q;
        quiet = !sync1_q && !sync2_q && !lvl_q;
`endif
        lvl_d = lvl;
        rise  = lvl && !lvl_q;
        fall  = !lvl && lvl_q;

        tmo = 1'b0;
        if (rise) begin
            frame_d = '0;
        end else if (frame_q == FT) begin
            frame_d = frame_q;
        end else begin
            frame_d = frame_q + 21'd1;
            tmo     = (frame_d == FT);
        end

        state_d  = state_q;
        width_d  = width_q;
        eval_d   = 1'b0;
        wout_d   = wout_q;
        ctr_d    = ctr_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        lock_d   = lock_q;
        locked_d = locked_q;
        drop     = 1'b0;

        // primed_q guarantees sync1_q holds a real sample, not its reset value
        unique case (state_q)
            WAIT_LOW: if (primed_q && quiet) state_d = ARMED;
            ARMED: begin
                if (rise) begin
                    state_d = HIGH;
                    width_d = 21'd1;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = LOW;
                    eval_d  = !tmo;
                end else begin
                    width_d = width_q + 21'd1;
                    if (width_d == MAXW) begin
                        err_d   = 1'b1;
                        drop    = 1'b1;
                        state_d = WAIT_LOW;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    width_d = 21'd1;
                end
            end
            default: state_d = WAIT_LOW;
        endcase

        if (eval_q && !tmo) begin
            if (width_q < MINW) begin
                err_d = 1'b1;
                drop  = 1'b1;
            end else begin
                valid_d = 1'b1;
                wout_d  = width_q;
                ctr_d   = decode(width_q);
                if (lock_q != LC) lock_d = lock_q + 1'b1;
                if (lock_d == LC) locked_d = 1'b1;
            end
        end

        if (tmo) begin
            err_d = 1'b1;
            drop  = 1'b1;
        end
        if (drop) begin
            lock_d   = '0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_LOW;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            lvl_q    <= 1'b0;
            primed_q <= 1'b0;
            eval_q   <= 1'b0;
            width_q  <= '0;
            frame_q  <= '0;
            wout_q   <= '0;
            ctr_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            lock_q   <= '0;
`ifdef PWM_GLITCH_FILTER_EN
            filt_q   <= 1'b0;
            fcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            lvl_q    <= lvl_d;
            primed_q <= primed_d;
            eval_q   <= eval_d;
            width_q  <= width_d;
            frame_q  <= frame_d;
            wout_q   <= wout_d;
            ctr_q    <= ctr_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            lock_q   <= lock_d;
`ifdef PWM_GLITCH_FILTER_EN
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
`endif
        end
    end

    assign ctr_out   = ctr_q;
    assign width_out = wout_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign err       = err_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with widths scaled down by 500 to keep runs short.
// Vector table, hand-written corner sequences, then randomized pulses vs a model.
module tb_servo_pwm_decoder;

    localparam int MINP  = 80;
    localparam int MAXP  = 600;
    localparam int TMO   = 2200;
    localparam int LOCKN = 2;
    localparam int FLEN  = 8;
    localparam int TH [6] = '{199, 269, 332, 398, 464, 523};
`ifdef PWM_GLITCH_FILTER_EN
    localparam int FEXTRA = FLEN;
`else
    localparam int FEXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [2:0]  ctr_out;
    logic [20:0] width_out;
    logic        valid, locked, err;

    always #5 clk = ~clk;

    servo_pwm_decoder #(
        .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .FRAME_TIMEOUT(TMO),
        .LOCK_COUNT(LOCKN), .FILTER_LEN(FLEN),
        .TH_010(TH[0]), .TH_011(TH[1]), .TH_100(TH[2]),
        .TH_101(TH[3]), .TH_110(TH[4]), .TH_111(TH[5])
    ) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .ctr_out(ctr_out), .width_out(width_out),
        .valid(valid), .locked(locked), .err(err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_valid = 0, n_err = 0, both = 0;
    int last_valid_cyc = 0, last_err_cyc = 0;
    int last_w = 0, last_c = 0;
    int rise_cyc = 0, fall_cyc = 0;
    int mlock = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
            last_w         <= int'(width_out);
            last_c         <= int'(ctr_out);
        end
        if (err) begin
            n_err        <= n_err + 1;
            last_err_cyc <= cyc;
        end
        if (valid && err) both <= both + 1;
    end

    typedef struct {
        int         w;
        logic [2:0] code;
        bit         bad;
    } vec_t;

    vec_t tbl [14];

    function automatic int ref_code(input int w);
        int c = 1;
        for (int i = 0; i < 6; i++)
            if (w >= TH[i]) c = i + 2;
        return c;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        @(negedge clk);
        pwm_in = 1'b1;
        rise_cyc = cyc;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        fall_cyc = cyc;
        repeat (lo) @(negedge clk);
        #2;
    endtask

    task automatic run_pulse(input int w, input int lo, input int code,
                             input bit bad, input string nm);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        pulse(w, lo);
        if (bad) mlock = 0;
        else if (mlock < LOCKN) mlock++;
        chk({nm, " valid"}, n_valid - v0, bad ? 0 : 1);
        chk({nm, " err"}, n_err - e0, bad ? 1 : 0);
        chk({nm, " locked"}, int'(locked), (mlock >= LOCKN) ? 1 : 0);
        if (!bad) begin
            chk({nm, " width"}, last_w, w);
            chk({nm, " code"}, last_c, code);
        end
    endtask

    initial begin
        int v0, e0, w, lo;
        tbl[0]  = '{160, 3'b001, 1'b0};
        tbl[1]  = '{238, 3'b010, 1'b0};
        tbl[2]  = '{364, 3'b100, 1'b0};
        tbl[3]  = '{432, 3'b101, 1'b0};
        tbl[4]  = '{496, 3'b110, 1'b0};
        tbl[5]  = '{550, 3'b111, 1'b0};
        tbl[6]  = '{198, 3'b001, 1'b0};
        tbl[7]  = '{199, 3'b010, 1'b0};
        tbl[8]  = '{300, 3'b011, 1'b0};
        tbl[9]  = '{60,  3'b000, 1'b1};
        tbl[10] = '{300, 3'b011, 1'b0};
        tbl[11] = '{600, 3'b000, 1'b1};
        tbl[12] = '{599, 3'b111, 1'b0};
        tbl[13] = '{300, 3'b011, 1'b0};

        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ctr", int'(ctr_out), 0);
        chk("reset width", int'(width_out), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset locked", int'(locked), 0);
        chk("reset err", int'(err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        run_pulse(300, 1700, 3, 1'b0, "frame1");
        chk("valid latency", last_valid_cyc - fall_cyc, 4 + FEXTRA);
        run_pulse(300, 1700, 3, 1'b0, "frame2");
        run_pulse(300, 1700, 3, 1'b0, "frame3");

        foreach (tbl[i])
            run_pulse(tbl[i].w, 1000, int'(tbl[i].code), tbl[i].bad,
                      $sformatf("tbl%0d", i));

        e0 = n_err;
        repeat (1500) @(negedge clk);
        #2;
        chk("timeout count", n_err - e0, 1);
        chk("timeout time", last_err_cyc - rise_cyc, TMO + 3 + FEXTRA);
        chk("timeout locked", int'(locked), 0);
        repeat (2500) @(negedge clk);
        #2;
        chk("timeout once", n_err - e0, 1);
        mlock = 0;
        run_pulse(300, 1000, 3, 1'b0, "relock1");
        run_pulse(300, 1000, 3, 1'b0, "relock2");

        @(negedge clk);
        rst = 1'b1;
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        mlock = 0;
        v0 = n_valid;
        e0 = n_err;
        repeat (200) @(negedge clk);
        pwm_in = 1'b0;
        repeat (300) @(negedge clk);
        #2;
        chk("inflight valid", n_valid - v0, 0);
        chk("inflight err", n_err - e0, 0);
        run_pulse(300, 1000, 3, 1'b0, "post rst1");
        run_pulse(300, 1000, 3, 1'b0, "post rst2");

        @(negedge clk);
        pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("high rst ctr", int'(ctr_out), 0);
        chk("high rst width", int'(width_out), 0);
        chk("high rst valid", int'(valid), 0);
        chk("high rst locked", int'(locked), 0);
        chk("high rst err", int'(err), 0);
        rst = 1'b0;
        mlock = 0;
        v0 = n_valid;
        repeat (100) @(negedge clk);
        pwm_in = 1'b0;
        repeat (300) @(negedge clk);
        #2;
        chk("high rst no valid", n_valid - v0, 0);

        v0 = n_valid;
        e0 = n_err;
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (140) @(negedge clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        pwm_in = 1'b1;
        repeat (157) @(negedge clk);
        pwm_in = 1'b0;
        repeat (1000) @(negedge clk);
        #2;
        chk("glitch err", n_err - e0, 0);
`ifdef PWM_GLITCH_FILTER_EN
        chk("glitch valids", n_valid - v0, 1);
        chk("glitch width", last_w, 300);
        chk("glitch code", last_c, 3);
        mlock = (mlock + 1 > LOCKN) ? LOCKN : mlock + 1;
`else
        chk("glitch valids", n_valid - v0, 2);
        chk("glitch width", last_w, 157);
        chk("glitch code", last_c, 1);
        mlock = (mlock + 2 > LOCKN) ? LOCKN : mlock + 2;
`endif
        chk("glitch locked", int'(locked), (mlock >= LOCKN) ? 1 : 0);

        for (int i = 0; i < 30; i++) begin
            w  = int'($urandom_range(40, 650));
            lo = int'($urandom_range(20, 300));
            run_pulse(w, lo, ref_code(w), (w < MINP) || (w >= MAXP),
                      $sformatf("rnd%0d w%0d", i, w));
        end

        chk("valid err exclusive", both, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
